// File: rtl/radix_bist_pkg.sv
// radix_bist_pkg: shared types and constants for the radix-4 multiplier
// self-test sequencer.
//   state_e    - sequencer FSM states
//   LFSR_TAPS  - feedback taps of the operand generator (x^16+x^14+x^13+x^11)
//   MISR_TAPS  - feedback taps of the signature register (same polynomial)
//   OPND_W     - multiplier operand width
//   PROD_W     - multiplier product width
//   lfsr_step / misr_step - one shift of the generator / compactor
package radix_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_COMPACT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] MISR_TAPS = 16'hB400;
  localparam int          OPND_W    = 8;
  localparam int          PROD_W    = 16;

  // Fibonacci shift: feedback bit is the XOR of the tapped bits.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [15:0] data);
    return {sig[14:0], ^(sig & MISR_TAPS)} ^ data;
  endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// bist_lfsr16: 16-bit Fibonacci LFSR used as the operand generator.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (state <= RESET_VALUE)
//   load       in   load load_value (has priority over en)
//   load_value in   16-bit value loaded on load
//   en         in   advance one step
//   state      out  current LFSR state
module bist_lfsr16
  import radix_bist_pkg::*;
#(
  parameter logic [15:0] RESET_VALUE = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_value;
    end else if (en) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_VALUE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/radix_bist_sequencer.sv
// radix_bist_sequencer: deterministic self-test run for the radix-4 8x8
// multiplier. On bist_start it drives VECTORS LFSR operand pairs through the
// multiplier (clear, launch, wait for ready), compacts each product into a
// 16-bit MISR and compares the final signature with GOLDEN.
// Ports:
//   clk, reset (async, active-low)
//   bist_start                       start pulse, honoured in IDLE/DONE
//   mult_reset, mult_start           multiplier clear / launch pulses
//   mult_x, mult_y                   operands (lfsr[15:8], lfsr[7:0])
//   mult_result, mult_ready          multiplier product / product-valid
//   bist_busy, bist_done, bist_pass, bist_timeout  run status
//   signature, vector_count          MISR value / vectors compacted
//   dbg_state                        current FSM state
// Build option: define RADIX_BIST_TIMEOUT_EN to add a per-vector watchdog
// that aborts the run after TIMEOUT WAIT cycles without mult_ready.
//
// Multiplier handshake: mult_start is a one-cycle launch issued only after a
// one-cycle mult_reset; the product on mult_result is taken in the cycle after
// the first WAIT cycle in which mult_ready is sampled high. mult_ready is not
// acknowledged - the next mult_reset discards it.
module radix_bist_sequencer
  import radix_bist_pkg::*;
#(
  parameter int          VECTORS = 64,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter logic [15:0] GOLDEN  = 16'h0000,
  parameter int          TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bist_start,
  output logic              mult_reset,
  output logic              mult_start,
  output logic [OPND_W-1:0] mult_x,
  output logic [OPND_W-1:0] mult_y,
  input  logic [PROD_W-1:0] mult_result,
  input  logic              mult_ready,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic              bist_timeout,
  output logic [15:0]       signature,
  output logic [7:0]        vector_count,
  output state_e            dbg_state
);

  // An all-zero seed would lock the LFSR.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [8:0]  VEC_LIMIT = 9'(VECTORS);

  state_e            state_q, state_d;
  logic [15:0]       sig_q, sig_d;
  logic [7:0]        vc_q, vc_d;
  logic [8:0]        vc_inc;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              mreset_q, mreset_d;
  logic              mstart_q, mstart_d;
  logic [OPND_W-1:0] x_q, x_d, y_q, y_d;
  logic              lfsr_load, lfsr_en;
  logic [15:0]       lfsr_state, lfsr_next;

`ifdef RADIX_BIST_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_q, wd_d;
  logic       tmo_q, tmo_d;
`endif

  bist_lfsr16 #(
    .RESET_VALUE(SEED_EFF)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (reset),
    .load      (lfsr_load),
    .load_value(SEED_EFF),
    .en        (lfsr_en),
    .state     (lfsr_state)
  );

  assign vc_inc    = {1'b0, vc_q} + 9'd1;
  assign lfsr_next = lfsr_step(lfsr_state);

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    vc_d      = vc_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    x_d       = x_q;
    y_d       = y_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
`ifdef RADIX_BIST_TIMEOUT_EN
    wd_d      = wd_q;
    tmo_d     = tmo_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bist_start) begin
          state_d   = S_CLEAR;
          sig_d     = 16'h0000;
          vc_d      = 8'h00;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          lfsr_load = 1'b1;
          // Operand registers mirror what the LFSR will hold from CLEAR on.
          x_d       = SEED_EFF[15:8];
          y_d       = SEED_EFF[7:0];
`ifdef RADIX_BIST_TIMEOUT_EN
          tmo_d     = 1'b0;
`endif
        end
      end
      S_CLEAR: state_d = S_START;
      S_START: begin
        state_d = S_WAIT;
`ifdef RADIX_BIST_TIMEOUT_EN
        wd_d    = 8'h00;
`endif
      end
      S_WAIT: begin
        // Ready has priority over a watchdog expiring in the same cycle.
        if (mult_ready) begin
          state_d = S_COMPACT;
`ifdef RADIX_BIST_TIMEOUT_EN
        end else if (wd_q == WD_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          wd_d    = wd_q + 8'h01;
`endif
        end
      end
      S_COMPACT: begin
        sig_d   = misr_step(sig_q, mult_result);
        vc_d    = vc_inc[7:0];
        lfsr_en = 1'b1;
        x_d     = lfsr_next[15:8];
        y_d     = lfsr_next[7:0];
        if (vc_inc < VEC_LIMIT) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (sig_d == GOLDEN);
        end
      end
      default: state_d = S_IDLE;
    endcase
    mreset_d = (state_d == S_CLEAR);
    mstart_d = (state_d == S_START);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      sig_q    <= 16'h0000;
      vc_q     <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      mreset_q <= 1'b0;
      mstart_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      vc_q     <= vc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      mreset_q <= mreset_d;
      mstart_q <= mstart_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

`ifdef RADIX_BIST_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q  <= 8'h00;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end
  assign bist_timeout = tmo_q;
`else
  assign bist_timeout = 1'b0;
`endif

  assign mult_reset   = mreset_q;
  assign mult_start   = mstart_q;
  assign mult_x       = x_q;
  assign mult_y       = y_q;
  assign bist_busy    = busy_q;
  assign bist_done    = done_q;
  assign bist_pass    = pass_q;
  assign signature    = sig_q;
  assign vector_count = vc_q;
  assign dbg_state    = state_q;

endmodule
